// File: rtl/dpdm_tx_arbiter.sv
// Shares the single DP/DM encoder between the NRZI data path and the handshake path.
// One owner at a time; the grant is held through the encoder EOP and followed by an inter-packet gap.
module dpdm_tx_arbiter #(
    parameter int IPG_CYCLES    = 4,
    parameter int START_TIMEOUT = 16,
    parameter int PH_PRIORITY   = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic nrzi_req,
    input  logic nrzi_in_bit,
    input  logic nrzi_sending,
    input  logic ph_req,
    input  logic ph_in_bit,
    input  logic ph_sending,
    input  logic enc_out_done,
    output logic enc_in_bit,
    output logic enc_sending,
    output logic nrzi_grant,
    output logic ph_grant,
    output logic nrzi_done,
    output logic ph_done,
    output logic timeout_err,
    output logic busy
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_GRANT = 3'd1;
    localparam logic [2:0] ST_SEND  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    localparam logic [7:0] GAP_LOAD = 8'(IPG_CYCLES - 1);
    localparam logic [7:0] TO_LAST  = 8'(START_TIMEOUT - 1);

    logic [2:0] state;
    logic [7:0] start_cnt;
    logic [7:0] gap_cnt;
    logic       winner_ph;
    logic       last_owner_ph;
    logic       pick_ph;
    logic       granted_sending;
    logic       granted_bit;

    // Only the registered grant selects the source, so the other requester is fully ignored.
    always_comb begin
        granted_sending = 1'b0;
        granted_bit     = 1'b0;
        if (nrzi_grant) begin
            granted_sending = nrzi_sending;
            granted_bit     = nrzi_in_bit;
        end else if (ph_grant) begin
            granted_sending = ph_sending;
            granted_bit     = ph_in_bit;
        end
    end

    always_comb begin
        if (ph_req && !nrzi_req)
            pick_ph = 1'b1;
        else if (nrzi_req && !ph_req)
            pick_ph = 1'b0;
        else if (PH_PRIORITY != 0)
            pick_ph = 1'b1;
        else
            pick_ph = !last_owner_ph;
    end

    assign enc_sending = granted_sending & ((state == ST_GRANT) || (state == ST_SEND));
    assign enc_in_bit  = granted_bit;
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            nrzi_grant    <= 1'b0;
            ph_grant      <= 1'b0;
            nrzi_done     <= 1'b0;
            ph_done       <= 1'b0;
            timeout_err   <= 1'b0;
            start_cnt     <= 8'd0;
            gap_cnt       <= 8'd0;
            winner_ph     <= 1'b0;
            last_owner_ph <= 1'b1;
        end else begin
            nrzi_done   <= 1'b0;
            ph_done     <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (nrzi_req || ph_req) begin
                        winner_ph  <= pick_ph;
                        ph_grant   <= pick_ph;
                        nrzi_grant <= !pick_ph;
                        start_cnt  <= 8'd0;
                        state      <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (granted_sending) begin
                        state <= ST_SEND;
                    end else if (start_cnt == TO_LAST) begin
                        // Owner never started: release straight to IDLE, no gap needed.
                        timeout_err   <= 1'b1;
                        nrzi_grant    <= 1'b0;
                        ph_grant      <= 1'b0;
                        last_owner_ph <= winner_ph;
                        state         <= ST_IDLE;
                    end else begin
                        start_cnt <= start_cnt + 8'd1;
                    end
                end
                ST_SEND: begin
                    if (!granted_sending)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (enc_out_done) begin
                        gap_cnt       <= GAP_LOAD;
                        nrzi_grant    <= 1'b0;
                        ph_grant      <= 1'b0;
                        nrzi_done     <= !winner_ph;
                        ph_done       <= winner_ph;
                        last_owner_ph <= winner_ph;
                        state         <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 8'd0)
                        state <= ST_IDLE;
                    else
                        gap_cnt <= gap_cnt - 8'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dpdm_tx_arbiter.sv
// Directed bench for dpdm_tx_arbiter: fixed-priority instance plus a round-robin instance on shared inputs.
module tb_dpdm_tx_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic nrzi_req = 1'b0, nrzi_in_bit = 1'b0, nrzi_sending = 1'b0;
    logic ph_req = 1'b0, ph_in_bit = 1'b0, ph_sending = 1'b0;
    logic enc_out_done = 1'b0;

    logic enc_in_bit, enc_sending, nrzi_grant, ph_grant, nrzi_done, ph_done, timeout_err, busy;
    logic rr_enc_in_bit, rr_enc_sending, rr_nrzi_grant, rr_ph_grant;
    logic rr_nrzi_done, rr_ph_done, rr_timeout_err, rr_busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    dpdm_tx_arbiter #(.IPG_CYCLES(4), .START_TIMEOUT(16), .PH_PRIORITY(1)) dut (
        .clock(clock), .reset(reset),
        .nrzi_req(nrzi_req), .nrzi_in_bit(nrzi_in_bit), .nrzi_sending(nrzi_sending),
        .ph_req(ph_req), .ph_in_bit(ph_in_bit), .ph_sending(ph_sending),
        .enc_out_done(enc_out_done),
        .enc_in_bit(enc_in_bit), .enc_sending(enc_sending),
        .nrzi_grant(nrzi_grant), .ph_grant(ph_grant),
        .nrzi_done(nrzi_done), .ph_done(ph_done),
        .timeout_err(timeout_err), .busy(busy)
    );

    dpdm_tx_arbiter #(.IPG_CYCLES(4), .START_TIMEOUT(16), .PH_PRIORITY(0)) dut_rr (
        .clock(clock), .reset(reset),
        .nrzi_req(nrzi_req), .nrzi_in_bit(nrzi_in_bit), .nrzi_sending(nrzi_sending),
        .ph_req(ph_req), .ph_in_bit(ph_in_bit), .ph_sending(ph_sending),
        .enc_out_done(enc_out_done),
        .enc_in_bit(rr_enc_in_bit), .enc_sending(rr_enc_sending),
        .nrzi_grant(rr_nrzi_grant), .ph_grant(rr_ph_grant),
        .nrzi_done(rr_nrzi_done), .ph_done(rr_ph_done),
        .timeout_err(rr_timeout_err), .busy(rr_busy)
    );

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic clear_inputs();
        nrzi_req = 0; nrzi_in_bit = 0; nrzi_sending = 0;
        ph_req = 0; ph_in_bit = 0; ph_sending = 0; enc_out_done = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1;
        step();
        #1;
        checks++;
        if ({nrzi_grant, ph_grant, nrzi_done, ph_done, timeout_err, busy, enc_sending, enc_in_bit} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 00000000",
                     {nrzi_grant, ph_grant, nrzi_done, ph_done, timeout_err, busy, enc_sending, enc_in_bit});
        end
        reset = 0;
    endtask

    task automatic test_nrzi_packet();
        logic [19:0] pat;
        pat = 20'hA5C3B;
        do_reset();
        nrzi_req = 1;
        #1;
        checks++;
        if (nrzi_grant !== 1'b0) begin errors++; $display("FAIL grant_early: got %b required 0", nrzi_grant); end
        step();
        nrzi_req = 0;
        for (int i = 0; i < 20; i++) begin
            nrzi_sending = 1; nrzi_in_bit = pat[i];
            #1;
            checks++;
            if (enc_sending !== 1'b1 || enc_in_bit !== pat[i] || nrzi_grant !== 1'b1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL nrzi_bit%0d: got s=%b b=%b g=%b busy=%b required s=1 b=%b g=1 busy=1",
                         i, enc_sending, enc_in_bit, nrzi_grant, busy, pat[i]);
            end
            step();
        end
        nrzi_sending = 0; nrzi_in_bit = 0;
        #1;
        checks++;
        if (enc_sending !== 1'b0 || nrzi_grant !== 1'b1) begin
            errors++; $display("FAIL nrzi_drop: got s=%b g=%b required s=0 g=1", enc_sending, nrzi_grant);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            #1;
            checks++;
            if (enc_sending !== 1'b0 || nrzi_grant !== 1'b1 || nrzi_done !== 1'b0) begin
                errors++;
                $display("FAIL drain%0d: got s=%b g=%b d=%b required s=0 g=1 d=0", i, enc_sending, nrzi_grant, nrzi_done);
            end
        end
        step();
        enc_out_done = 1;
        step();
        enc_out_done = 0;
        #1;
        checks++;
        if (nrzi_done !== 1'b1 || nrzi_grant !== 1'b0 || busy !== 1'b1 || ph_done !== 1'b0) begin
            errors++;
            $display("FAIL nrzi_done: got d=%b g=%b busy=%b phd=%b required d=1 g=0 busy=1 phd=0",
                     nrzi_done, nrzi_grant, busy, ph_done);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            checks++;
            if (nrzi_done !== 1'b0 || busy !== 1'b1 || nrzi_grant !== 1'b0) begin
                errors++;
                $display("FAIL gap%0d: got d=%b busy=%b g=%b required d=0 busy=1 g=0", i + 2, nrzi_done, busy, nrzi_grant);
            end
        end
        step();
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL gap_end_busy: got %b required 0", busy); end
    endtask

    task automatic test_tie_priority();
        do_reset();
        nrzi_req = 1; ph_req = 1;
        step();
        #1;
        checks++;
        if (ph_grant !== 1'b1 || nrzi_grant !== 1'b0) begin
            errors++; $display("FAIL tie_prio: got ph=%b nrzi=%b required ph=1 nrzi=0", ph_grant, nrzi_grant);
        end
        for (int i = 0; i < 3; i++) begin
            ph_sending = 1; ph_in_bit = i[0]; nrzi_in_bit = ~i[0];
            #1;
            checks++;
            if (enc_sending !== 1'b1 || enc_in_bit !== i[0]) begin
                errors++; $display("FAIL ph_bit%0d: got s=%b b=%b required s=1 b=%b", i, enc_sending, enc_in_bit, i[0]);
            end
            step();
        end
        ph_sending = 0;
        step();
        enc_out_done = 1;
        step();
        enc_out_done = 0;
        #1;
        checks++;
        if (ph_done !== 1'b1 || ph_grant !== 1'b0 || nrzi_grant !== 1'b0) begin
            errors++; $display("FAIL ph_done: got d=%b ph=%b nrzi=%b required d=1 ph=0 nrzi=0", ph_done, ph_grant, nrzi_grant);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            #1;
            checks++;
            if (nrzi_grant !== 1'b0 || ph_grant !== 1'b0) begin
                errors++; $display("FAIL gap_req_ignored%0d: got nrzi=%b ph=%b required 0 0", i, nrzi_grant, ph_grant);
            end
        end
        ph_req = 0;
        step();
        #1;
        checks++;
        if (nrzi_grant !== 1'b1 || ph_grant !== 1'b0) begin
            errors++; $display("FAIL second_grant: got nrzi=%b ph=%b required nrzi=1 ph=0", nrzi_grant, ph_grant);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        nrzi_req = 1; ph_req = 1;
        step();
        #1;
        checks++;
        if (rr_nrzi_grant !== 1'b1 || rr_ph_grant !== 1'b0) begin
            errors++; $display("FAIL rr_first: got nrzi=%b ph=%b required nrzi=1 ph=0", rr_nrzi_grant, rr_ph_grant);
        end
        nrzi_sending = 1;
        step();
        nrzi_sending = 0;
        step();
        enc_out_done = 1;
        step();
        enc_out_done = 0;
        #1;
        checks++;
        if (rr_nrzi_done !== 1'b1) begin errors++; $display("FAIL rr_nrzi_done: got %b required 1", rr_nrzi_done); end
        for (int i = 0; i < 5; i++) step();
        #1;
        checks++;
        if (rr_ph_grant !== 1'b1 || rr_nrzi_grant !== 1'b0) begin
            errors++; $display("FAIL rr_second: got ph=%b nrzi=%b required ph=1 nrzi=0", rr_ph_grant, rr_nrzi_grant);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        ph_req = 1; nrzi_req = 1;
        step();
        ph_req = 0;
        for (int i = 1; i <= 16; i++) begin
            #1;
            checks++;
            if (ph_grant !== 1'b1 || timeout_err !== 1'b0 || enc_sending !== 1'b0) begin
                errors++;
                $display("FAIL grant_wait%0d: got g=%b to=%b s=%b required g=1 to=0 s=0", i, ph_grant, timeout_err, enc_sending);
            end
            step();
        end
        #1;
        checks++;
        if (timeout_err !== 1'b1 || ph_grant !== 1'b0 || nrzi_grant !== 1'b0 || busy !== 1'b0 || ph_done !== 1'b0) begin
            errors++;
            $display("FAIL timeout: got to=%b ph=%b nrzi=%b busy=%b phd=%b required 1 0 0 0 0",
                     timeout_err, ph_grant, nrzi_grant, busy, ph_done);
        end
        step();
        #1;
        checks++;
        if (nrzi_grant !== 1'b1 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL after_timeout: got nrzi=%b to=%b required nrzi=1 to=0", nrzi_grant, timeout_err);
        end
    endtask

    task automatic test_isolation();
        do_reset();
        nrzi_req = 1;
        step();
        for (int i = 0; i < 6; i++) begin
            nrzi_sending = 1; nrzi_in_bit = i[0];
            ph_sending = i[1]; ph_in_bit = ~i[0];
            enc_out_done = (i == 3);
            #1;
            checks++;
            if (enc_sending !== 1'b1 || enc_in_bit !== i[0]) begin
                errors++; $display("FAIL iso_bit%0d: got s=%b b=%b required s=1 b=%b", i, enc_sending, enc_in_bit, i[0]);
            end
            step();
        end
        enc_out_done = 0;
        nrzi_sending = 0; ph_sending = 1;
        #1;
        checks++;
        if (enc_sending !== 1'b0 || nrzi_grant !== 1'b1 || nrzi_done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL iso_stray_done: got s=%b g=%b d=%b busy=%b required s=0 g=1 d=0 busy=1",
                     enc_sending, nrzi_grant, nrzi_done, busy);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        ph_req = 1;
        step();
        ph_sending = 1;
        step();
        step();
        reset = 1;
        #1;
        checks++;
        if (enc_sending !== 1'b1) begin errors++; $display("FAIL pre_reset_send: got %b required 1", enc_sending); end
        step();
        #1;
        checks++;
        if ({ph_grant, nrzi_grant, enc_sending, ph_done, nrzi_done, timeout_err, busy} !== 7'b0) begin
            errors++;
            $display("FAIL mid_reset: got %b required 0000000",
                     {ph_grant, nrzi_grant, enc_sending, ph_done, nrzi_done, timeout_err, busy});
        end
        reset = 0;
        step();
        #1;
        checks++;
        if (ph_grant !== 1'b1 || ph_done !== 1'b0) begin
            errors++; $display("FAIL regrant: got g=%b d=%b required g=1 d=0", ph_grant, ph_done);
        end
    endtask

    task automatic test_drain_repulse();
        int done_cnt;
        do_reset();
        nrzi_req = 1;
        step();
        nrzi_req = 0;
        nrzi_sending = 1;
        step();
        step();
        nrzi_sending = 0;
        step();
        for (int i = 0; i < 4; i++) begin
            nrzi_sending = ~i[0];
            #1;
            checks++;
            if (enc_sending !== 1'b0 || nrzi_grant !== 1'b1 || ph_grant !== 1'b0) begin
                errors++;
                $display("FAIL drain_repulse%0d: got s=%b nrzi=%b ph=%b required s=0 nrzi=1 ph=0",
                         i, enc_sending, nrzi_grant, ph_grant);
            end
            step();
        end
        enc_out_done = 1;
        step();
        enc_out_done = 0;
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            nrzi_sending = i[0];
            #1;
            if (nrzi_done === 1'b1) done_cnt++;
            checks++;
            if ((nrzi_grant & ph_grant) !== 1'b0) begin
                errors++; $display("FAIL grant_overlap%0d: got both=%b required 0", i, nrzi_grant & ph_grant);
            end
            step();
        end
        nrzi_sending = 0;
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL done_count: got %0d required 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_nrzi_packet();
        test_tie_priority();
        test_round_robin();
        test_timeout();
        test_isolation();
        test_reset_mid_packet();
        test_drain_repulse();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
